des_key_schedule: RTL and testbench

- Iterative DES key-schedule engine: accepts a 64-bit key, applies PC-1, and issues the sixteen 48-bit round subkeys one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits between the key input register and the round datapath, and instantiates `rotate_left` for encrypt-direction shifts.

---
 rtl/des_key_schedule.sv | 176 +++++++++++++++++
 tb/tb_des_key_schedule.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on start, one PC-2 subkey per ready handshake, K1..K16 or K16..K1.
// First subkey one cycle after start; subkey/round hold under backpressure. Optional DES_KEY_PARITY_CHK_EN.

module rotate_left (
   input  logic [4:0]  level,
   input  logic [28:1] c_in,
   input  logic [28:1] d_in,
   output logic [28:1] c_out,
   output logic [28:1] d_out
);
   always_comb begin
      c_out = {c_in[26:1], c_in[28:27]};
      d_out = {d_in[26:1], d_in[28:27]};
      if (level == 5'd1 || level == 5'd2 || level == 5'd9 || level == 5'd16) begin
         c_out = {c_in[27:1], c_in[28]};
         d_out = {d_in[27:1], d_in[28]};
      end
   end
endmodule

module des_key_schedule (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_decrypt,
   input  logic [64:1] i_key,
   input  logic        i_subkey_ready,
   output logic [48:1] o_subkey,
   output logic        o_subkey_valid,
   output logic [5:1]  o_round,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_parity_err
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4};

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32};

   // Vectors are MSB-first: DES bit n of the key lives at index 65-n.
   function automatic logic [56:1] pc1(input logic [64:1] k);
      logic [56:1] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[56-i] = k[65-PC1[i]];
      return r;
   endfunction

   function automatic logic [48:1] pc2(input logic [56:1] cd);
      logic [48:1] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[48-i] = cd[57-PC2[i]];
      return r;
   endfunction

   state_t      state_q;
   logic [28:1] c_q, d_q;
   logic [4:0]  round_q;
   logic        dec_q;
   logic        done_q;

   logic [56:1] cd0;
   logic [4:0]  next_round;
   logic [4:0]  rot_level;
   logic [28:1] rot_c_in, rot_d_in, rot_c, rot_d;
   logic [28:1] ror_c, ror_d;
   logic        key_ok;

   assign cd0        = pc1(i_key);
   assign next_round = round_q + 5'd1;

   // One rotator serves both the start load (level 1) and encrypt advances.
   assign rot_level = (state_q == IDLE) ? 5'd1 : next_round;
   assign rot_c_in  = (state_q == IDLE) ? cd0[56:29] : c_q;
   assign rot_d_in  = (state_q == IDLE) ? cd0[28:1]  : d_q;

   rotate_left u_rotl (
      .level (rot_level),
      .c_in  (rot_c_in),
      .d_in  (rot_d_in),
      .c_out (rot_c),
      .d_out (rot_d)
   );

   // Decrypt walks the schedule backwards, undoing the shift of level 18-next_round.
   always_comb begin
      ror_c = {c_q[2:1], c_q[28:3]};
      ror_d = {d_q[2:1], d_q[28:3]};
      if (next_round == 5'd2 || next_round == 5'd9 || next_round == 5'd16) begin
         ror_c = {c_q[1], c_q[28:2]};
         ror_d = {d_q[1], d_q[28:2]};
      end
   end

`ifdef DES_KEY_PARITY_CHK_EN
   logic perr_q;

   always_comb begin
      key_ok = 1'b1;
      for (int b = 0; b < 8; b++) key_ok = key_ok & (^i_key[8*b+1 +: 8]);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) perr_q <= 1'b0;
      else          perr_q <= (state_q == IDLE) && i_start && !key_ok;
   end

   assign o_parity_err = perr_q;
`else
   assign key_ok       = 1'b1;
   assign o_parity_err = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
         dec_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_start && key_ok) begin
                  state_q <= RUN;
                  round_q <= 5'd1;
                  dec_q   <= i_decrypt;
                  c_q     <= i_decrypt ? cd0[56:29] : rot_c;
                  d_q     <= i_decrypt ? cd0[28:1]  : rot_d;
               end
            end
            RUN: begin
               if (i_subkey_ready) begin
                  if (round_q == 5'd16) begin
                     state_q <= IDLE;
                     round_q <= '0;
                     c_q     <= '0;
                     d_q     <= '0;
                     done_q  <= 1'b1;
                  end else begin
                     round_q <= next_round;
                     c_q     <= dec_q ? ror_c : rot_c;
                     d_q     <= dec_q ? ror_d : rot_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_subkey_valid = (state_q == RUN);
   assign o_busy         = (state_q == RUN);
   assign o_subkey       = (state_q == RUN) ? pc2({c_q, d_q}) : '0;
   assign o_round        = round_q;
   assign o_done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule against the classic 0x133457799BBCDFF1 subkey table.
module tb_des_key_schedule;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_decrypt = 1'b0;
   logic [64:1] i_key = '0;
   logic        i_subkey_ready = 1'b0;
   logic [48:1] o_subkey;
   logic        o_subkey_valid;
   logic [5:1]  o_round;
   logic        o_busy;
   logic        o_done;
   logic        o_parity_err;

   int total = 0;
   int bad   = 0;

   localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
   localparam logic [63:0] BAD_KEY = 64'h123457799BBCDFF1;

   logic [47:0] kx [1:16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

   des_key_schedule dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_start        (i_start),
      .i_decrypt      (i_decrypt),
      .i_key          (i_key),
      .i_subkey_ready (i_subkey_ready),
      .o_subkey       (o_subkey),
      .o_subkey_valid (o_subkey_valid),
      .o_round        (o_round),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_parity_err   (o_parity_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start(input logic [63:0] key, input logic dec);
      i_key     = key;
      i_decrypt = dec;
      i_start   = 1'b1;
      step();
      i_start   = 1'b0;
      i_key     = '0;
      i_decrypt = ~dec;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"},  64'(o_subkey_valid), 64'd0);
      chk({tag, "_subkey"}, 64'(o_subkey),       64'd0);
      chk({tag, "_round"},  64'(o_round),        64'd0);
      chk({tag, "_busy"},   64'(o_busy),         64'd0);
   endtask

   int          idx;
   int          cycles;
   logic        hs;
   logic [7:0]  lfsr;

   initial begin
      #3;
      chk_idle("rst");
      chk("rst_done", 64'(o_done),       64'd0);
      chk("rst_perr", 64'(o_parity_err), 64'd0);
      #10 i_rst_n = 1'b1;
      step();
      i_subkey_ready = 1'b1;

      // Encrypt, ready held high
      start(KEY, 1'b0);
      for (int r = 1; r <= 16; r++) begin
         chk($sformatf("enc_valid_%0d", r),  64'(o_subkey_valid), 64'd1);
         chk($sformatf("enc_round_%0d", r),  64'(o_round),        64'(r));
         chk($sformatf("enc_subkey_%0d", r), 64'(o_subkey),       64'(kx[r]));
         step();
      end
      chk("enc_done", 64'(o_done), 64'd1);
      chk_idle("enc_end");

      // Back-to-back decrypt start on the done cycle
      i_key = KEY; i_decrypt = 1'b1; i_start = 1'b1;
      step();
      i_start = 1'b0; i_key = '0; i_decrypt = 1'b0;
      chk("b2b_done_low", 64'(o_done), 64'd0);
      for (int r = 1; r <= 16; r++) begin
         chk($sformatf("dec_round_%0d", r),  64'(o_round),  64'(r));
         chk($sformatf("dec_subkey_%0d", r), 64'(o_subkey), 64'(kx[17-r]));
         step();
      end
      chk("dec_done", 64'(o_done), 64'd1);
      step();
      chk("dec_done_pulse", 64'(o_done), 64'd0);

      // Start with a different key during RUN must be ignored
      start(KEY, 1'b0);
      for (int r = 1; r <= 16; r++) begin
         chk($sformatf("ign_round_%0d", r),  64'(o_round),  64'(r));
         chk($sformatf("ign_subkey_%0d", r), 64'(o_subkey), 64'(kx[r]));
         if (r == 5) begin
            i_start = 1'b1; i_key = 64'hFEDCBA9876543210; i_decrypt = 1'b1;
         end else begin
            i_start = 1'b0;
         end
         step();
      end
      chk("ign_done", 64'(o_done), 64'd1);
      step();

      // Backpressure with pseudo-random ready
      start(KEY, 1'b0);
      idx = 1; cycles = 0; lfsr = 8'hA5;
      while (!o_done && cycles < 200) begin
         if (idx <= 16) begin
            chk($sformatf("bp_valid_c%0d", cycles),  64'(o_subkey_valid), 64'd1);
            chk($sformatf("bp_round_c%0d", cycles),  64'(o_round),        64'(idx));
            chk($sformatf("bp_subkey_c%0d", cycles), 64'(o_subkey),       64'(kx[idx]));
         end
         lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         i_subkey_ready = lfsr[0];
         hs = i_subkey_ready & o_subkey_valid;
         step();
         if (hs) idx++;
         cycles++;
      end
      chk("bp_handshakes", 64'(idx), 64'd17);
      chk("bp_done", 64'(o_done), 64'd1);
      i_subkey_ready = 1'b1;
      step();

      // Asynchronous reset at round 8
      start(KEY, 1'b0);
      for (int r = 1; r < 8; r++) step();
      chk("rst8_round", 64'(o_round), 64'd8);
      #2 i_rst_n = 1'b0;
      #1;
      chk_idle("rst8");
      chk("rst8_done", 64'(o_done), 64'd0);
      #3 i_rst_n = 1'b1;
      step();
      start(KEY, 1'b0);
      chk("rst8_restart_round",  64'(o_round),  64'd1);
      chk("rst8_restart_subkey", 64'(o_subkey), 64'(kx[1]));
      for (int n = 0; n < 20 && o_busy; n++) step();
      chk("rst8_drain", 64'(o_busy), 64'd0);
      step();

      // Key with a parity error in the first byte
      start(BAD_KEY, 1'b0);
`ifdef DES_KEY_PARITY_CHK_EN
      chk("par_err_pulse", 64'(o_parity_err), 64'd1);
      chk_idle("par_err");
      step();
      chk("par_err_clear", 64'(o_parity_err), 64'd0);
      chk("par_err_busy",  64'(o_busy),       64'd0);
`else
      chk("par_off_perr",   64'(o_parity_err), 64'd0);
      chk("par_off_busy",   64'(o_busy),       64'd1);
      chk("par_off_subkey", 64'(o_subkey),     64'(kx[1]));
      for (int n = 0; n < 20 && o_busy; n++) step();
      step();
`endif
      start(KEY, 1'b0);
      chk("par_ok_perr",   64'(o_parity_err),   64'd0);
      chk("par_ok_valid",  64'(o_subkey_valid), 64'd1);
      chk("par_ok_subkey", 64'(o_subkey),       64'(kx[1]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
